// File: rtl/bit_scan_ctrl.sv
// bit_scan_ctrl: walks every set bit of a loaded bitmap word, MSB-first,
// emitting one bit index per accepted output beat under valid/ready flow
// control. A small priority encoder locates the highest remaining set bit.

// Priority encoder: index of the highest set bit of in_vec (0 when empty).
module prio_enc #(
    parameter int WIDTH_LOG = 4
) (
    input  logic [(1<<WIDTH_LOG)-1:0] in_vec,
    output logic [WIDTH_LOG-1:0]      msb
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    // Ascending scan so the highest set bit is the last one to assign msb.
    always_comb begin
        msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
                msb = i[WIDTH_LOG-1:0];
            end
        end
    end
endmodule

module bit_scan_ctrl #(
    parameter int WIDTH_LOG = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(1<<WIDTH_LOG)-1:0]  in_data,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_LOG-1:0]       out_idx,
    output logic                       out_last,
    output logic                       done,
    output logic [WIDTH_LOG:0]         count
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam logic [WIDTH-1:0]   MASK_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_LOG:0] COUNT_ONE = {{WIDTH_LOG{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mask;
    logic [WIDTH_LOG:0]     r_count;
    logic                   r_done;

    logic [WIDTH_LOG-1:0]   w_msb;
    logic [WIDTH-1:0]       w_mask_dec;
    logic [WIDTH-1:0]       w_msb_onehot;
    logic                   w_last;
    logic                   w_load;
    logic                   w_fire;
    logic                   w_in_zero;

    prio_enc #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_prio_enc (
        .in_vec (r_mask),
        .msb    (w_msb)
    );

    // A word with at most one bit left means the current index is the last.
    assign w_mask_dec   = r_mask - MASK_ONE;
    assign w_last       = ((r_mask & w_mask_dec) == '0);
    assign w_msb_onehot = MASK_ONE << w_msb;
    assign w_in_zero    = (in_data == '0);
    assign w_load       = in_valid && in_ready;
    assign w_fire       = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: abort dominates; a word leaves SCAN once its last index is taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load && !w_in_zero) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_fire && w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs: both handshakes are gated combinationally by abort.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = !abort;
            S_SCAN:  out_valid = !abort;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        out_idx  = w_msb;
        out_last = w_last;
        done     = r_done;
        count    = r_count;
    end

    // Datapath: remaining-bit mask, emitted-index count and the done pulse.
    // An empty word pulses done straight away; an aborted word keeps its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_mask  <= in_data;
                r_count <= '0;
                r_done  <= w_in_zero;
            end else if ((r_state == S_SCAN) && abort) begin
                r_mask <= '0;
            end else if (w_fire) begin
                r_mask  <= r_mask & ~w_msb_onehot;
                r_count <= r_count + COUNT_ONE;
                r_done  <= w_last;
            end
        end
    end
endmodule

// File: tb/tb_bit_scan_ctrl.sv
// Bench for bit_scan_ctrl: random bitmap words with random back-pressure and
// aborts, checked against a list of expected indices built from each word.
module tb_bit_scan_ctrl;
    localparam int WL = 4;
    localparam int W  = 1 << WL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [WL-1:0] out_idx;
    logic          out_last;
    logic          done;
    logic [WL:0]   count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    bit exp_done = 1'b0;
    int exp_count = 0;

    bit_scan_ctrl #(.WIDTH_LOG(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected emission order: indices of set bits, highest first.
    function automatic void build_model(input logic [W-1:0] d);
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) exp_q.push_back(i);
        end
    endfunction

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        $display("reset: in_ready=%b out_valid=%b done=%b count=%0d", in_ready, out_valid, done, count);
        @(posedge clk); #1;
        exp_done = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_random(input int n_words);
        logic [W-1:0] d;
        int  abort_at;
        int  emitted;
        int  cycles;
        bit  aborted;
        bit  full_rate;
        for (int w = 0; w < n_words; w++) begin
            abort_at  = -1;
            full_rate = 1'b0;
            case (w)
                0: begin d = 16'h8421; full_rate = 1'b1; end
                1: d = 16'h0000;
                2: begin d = 16'hFFFF; full_rate = 1'b1; end
                3: begin d = 16'h00F0; full_rate = 1'b1; abort_at = 2; end
                4: d = 16'h0000;
                default: begin
                    case ($urandom_range(0, 5))
                        0: d = '0;
                        1: d = '1;
                        2: d = W'(1) << $urandom_range(0, W - 1);
                        default: d = W'($urandom);
                    endcase
                end
            endcase
            build_model(d);
            if (w > 4 && exp_q.size() > 0 && $urandom_range(0, 3) == 0)
                abort_at = $urandom_range(0, exp_q.size() - 1);

            // Optional idle cycle in which abort must block the offered load.
            if (w > 4 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1; in_data = d; abort = 1'b1; out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n_checks++; if (in_ready !== 1'b0) $display("FAIL idle_abort_ready: got %b want 0", in_ready); else n_pass++;
                n_checks++; if (done !== exp_done) $display("FAIL idle_done: got %b want %b", done, exp_done); else n_pass++;
                @(posedge clk); #1;
                abort = 1'b0;
                exp_done = 1'b0;
            end

            in_valid = 1'b1; in_data = d; abort = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", in_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL load_out_valid: got %b want 0", out_valid); else n_pass++;
            n_checks++; if (done !== exp_done) $display("FAIL load_done: got %b want %b", done, exp_done); else n_pass++;
            n_checks++; if (int'(count) !== exp_count) $display("FAIL load_count: got %0d want %0d", count, exp_count); else n_pass++;
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);

            emitted = 0; aborted = 1'b0; cycles = 0;
            while (emitted < exp_q.size() && !aborted) begin
                out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
                abort     = (emitted == abort_at);
                @(negedge clk);
                n_checks++; if (in_ready !== 1'b0) $display("FAIL scan_in_ready: got %b want 0", in_ready); else n_pass++;
                n_checks++; if (out_valid !== !abort) $display("FAIL scan_out_valid: got %b want %b", out_valid, !abort); else n_pass++;
                if (!abort) begin
                    n_checks++; if (int'(out_idx) !== exp_q[emitted]) $display("FAIL scan_idx: got %0d want %0d", out_idx, exp_q[emitted]); else n_pass++;
                    n_checks++; if (out_last !== (emitted == exp_q.size() - 1)) $display("FAIL scan_last: got %b want %b", out_last, emitted == exp_q.size() - 1); else n_pass++;
                end
                n_checks++; if (done !== 1'b0) $display("FAIL scan_done: got %b want 0", done); else n_pass++;
                n_checks++; if (int'(count) !== emitted) $display("FAIL scan_count: got %0d want %0d", count, emitted); else n_pass++;
                @(posedge clk); #1;
                if (abort) begin
                    aborted = 1'b1;
                    abort = 1'b0;
                end else if (out_ready) begin
                    emitted++;
                end
                cycles++;
                if (cycles > 200) begin
                    n_checks++;
                    $display("FAIL scan_budget: got %0d cycles want at most 200", cycles);
                    break;
                end
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            if (full_rate && !aborted) begin
                n_checks++; if (cycles !== exp_q.size()) $display("FAIL throughput: got %0d cycles want %0d", cycles, exp_q.size()); else n_pass++;
            end
            exp_done  = !aborted;
            exp_count = emitted;
            $display("word %0d: data=%h beats=%0d aborted=%b cycles=%0d", w, d, emitted, aborted, cycles);
        end
        @(negedge clk);
        n_checks++; if (done !== exp_done) $display("FAIL final_done: got %b want %b", done, exp_done); else n_pass++;
        n_checks++; if (int'(count) !== exp_count) $display("FAIL final_count: got %0d want %0d", count, exp_count); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 16'h0300; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_load_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({out_valid, out_idx, out_last} !== {1'b1, 4'd9, 1'b0}) $display("FAIL stall_hold: got valid=%b idx=%0d last=%b want 1/9/0", out_valid, out_idx, out_last); else n_pass++;
            n_checks++; if (count !== '0) $display("FAIL stall_count: got %0d want 0", count); else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_valid, out_idx, out_last} !== {1'b1, 4'd9, 1'b0}) $display("FAIL stall_beat0: got valid=%b idx=%0d last=%b want 1/9/0", out_valid, out_idx, out_last); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if ({out_valid, out_idx, out_last} !== {1'b1, 4'd8, 1'b1}) $display("FAIL stall_beat1: got valid=%b idx=%0d last=%b want 1/8/1", out_valid, out_idx, out_last); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, done} !== 2'b01) $display("FAIL stall_done: got valid=%b done=%b want 0/1", out_valid, done); else n_pass++;
        n_checks++; if (count !== 5'd2) $display("FAIL stall_final_count: got %0d want 2", count); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL stall_done_width: got %b want 0", done); else n_pass++;
        $display("stall: word 0300 held at idx 9 for 3 cycles, count=%0d", count);
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 16'h00F0; out_ready = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL arst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL arst_count: got %0d want 0", count); else n_pass++;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if ({out_valid, count} !== 6'd0) $display("FAIL arst_release: got valid=%b count=%0d want 0/0", out_valid, count); else n_pass++;
        $display("async reset: in_ready=%b out_valid=%b count=%0d", in_ready, out_valid, count);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_random(80);
        test_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
